// File: rtl/recibidor_serial_8b.sv
// Serial-to-byte receiver: hunts for SYNC_BYTE alignment on a 1-bit stream at clk_32f,
// goes active after SYNC_COUNT aligned sync bytes, then emits one byte per 8 bits.
module recibidor_serial_8b #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] SYNC_TARGET = CNT_W'(SYNC_COUNT);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {HUNT, LOCK, ACTIVE} state_t;

  state_t              state, state_d;
  logic [BYTE_W-1:0]   sr;
  logic [BYTE_W-1:0]   w;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0]    bc_cnt, bc_cnt_d;
  logic [CNT_W-1:0]    bc_inc;
  logic [BYTE_W-1:0]   data_d;
  logic                valid_d;
  logic                active_d;
  logic                is_sync;
  logic                boundary;

  // Sliding window: the last 8 bits including the one sampled on this edge
  assign w        = {sr[BYTE_W-2:0], data_in};
  assign is_sync  = (w == SYNC_BYTE);
  assign boundary = (bit_cnt == LAST_BIT);
  assign bc_inc   = bc_cnt + CNT_W'(1);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= w;
      bit_cnt   <= bit_cnt_d;
      bc_cnt    <= bc_cnt_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      active    <= active_d;
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bc_cnt_d  = bc_cnt;
    data_d    = data_out;
    valid_d   = valid_out;
    active_d  = active;
    case (state)
      HUNT: begin
        bit_cnt_d = '0;
        if (is_sync) begin
          bc_cnt_d = CNT_W'(1);
          if (SYNC_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        bit_cnt_d = bit_cnt + CNT_W'(1);
        if (boundary) begin
          if (is_sync) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == SYNC_TARGET) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d  = HUNT;
            bc_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt + CNT_W'(1);
        // Sync bytes are idle fill: drop valid but keep the last data byte
        if (boundary) begin
          if (is_sync) begin
            valid_d = 1'b0;
          end else begin
            data_d  = w;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

endmodule
